any1_issue_unit: RTL and testbench



---
 rtl/any1_issue_unit.sv | 144 ++++++++++++++
 tb/tb_any1_issue_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/any1_issue_unit.sv
// Single-slot issue unit: takes one scheduler pick, holds it for execute, then writes back.
// Optional watchdog enabled by defining ANY1_ISSUE_TIMEOUT_EN.
module any1_issue_unit #(
    parameter int unsigned ROB_ENTRIES    = 64,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  selection,
    input  logic [31:0] sel_ir,
    input  logic [63:0] sel_a,
    input  logic [63:0] sel_b,
    input  logic [63:0] sel_c,
    input  logic        flush,
    output logic        issue_ready,
    output logic        out_set,
    output logic [5:0]  out_rid,
    output logic        ex_valid,
    output logic [5:0]  ex_rid,
    output logic [31:0] ex_ir,
    output logic [63:0] ex_a,
    output logic [63:0] ex_b,
    output logic [63:0] ex_c,
    input  logic        ex_done,
    input  logic [63:0] ex_res,
    input  logic [7:0]  ex_exc,
    output logic        wb_v,
    output logic [5:0]  wb_rid,
    output logic [63:0] wb_res,
    output logic [7:0]  wb_exc
);

    localparam logic [7:0] TIMEOUT_EXC = 8'hFE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   set_q;
    logic   accept;
    logic   timeout_hit;

    // Rob index is fixed at 6 bits, so the slot count cannot exceed 64.
    if (ROB_ENTRIES == 0 || ROB_ENTRIES > 64 || TIMEOUT_CYCLES == 8'd0) begin : g_bad_cfg
        $error("any1_issue_unit: unsupported ROB_ENTRIES/TIMEOUT_CYCLES");
    end

    assign accept = (state == IDLE) && !selection[6] && !flush;

`ifdef ANY1_ISSUE_TIMEOUT_EN
    logic [7:0] wd_cnt;

    // Watchdog counts EXEC cycles that end without a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= 8'd0;
        end else if (accept) begin
            wd_cnt <= 8'd0;
        end else if (state == EXEC && !ex_done && !flush) begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    assign timeout_hit = (state == EXEC) && !ex_done && (wd_cnt == TIMEOUT_CYCLES - 8'd1);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = EXEC;
                EXEC:    if (ex_done || timeout_hit) state_nxt = WB;
                WB:      state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Strobes are gated by flush/rst so they vanish in the cycle those arrive.
    always_comb begin
        issue_ready = 1'b0;
        ex_valid    = 1'b0;
        out_set     = 1'b0;
        wb_v        = 1'b0;
        if (!rst && !flush) begin
            issue_ready = (state == IDLE);
            ex_valid    = (state == EXEC);
            out_set     = set_q;
            wb_v        = (state == WB);
        end
    end

    assign out_rid = ex_rid;
    assign wb_rid  = ex_rid;

    // Operand capture on accept; ex_rid holds through WB so writeback reports the issuing slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            set_q  <= 1'b0;
            ex_rid <= 6'd0;
            ex_ir  <= 32'd0;
            ex_a   <= 64'd0;
            ex_b   <= 64'd0;
            ex_c   <= 64'd0;
            wb_res <= 64'd0;
            wb_exc <= 8'd0;
        end else begin
            set_q <= accept;
            if (accept) begin
                ex_rid <= selection[5:0];
                ex_ir  <= sel_ir;
                ex_a   <= sel_a;
                ex_b   <= sel_b;
                ex_c   <= sel_c;
            end
            if (state == EXEC && !flush) begin
                if (ex_done) begin
                    wb_res <= ex_res;
                    wb_exc <= ex_exc;
                end else if (timeout_hit) begin
                    wb_res <= 64'd0;
                    wb_exc <= TIMEOUT_EXC;
                end
            end
        end
    end

endmodule

// File: tb/tb_any1_issue_unit.sv
// Randomised + directed bench for any1_issue_unit using an op-level reference model and scoreboard queues.
module tb_any1_issue_unit;

    localparam logic [7:0] TO = 8'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  selection = 7'h7F;
    logic [31:0] sel_ir = 32'd0;
    logic [63:0] sel_a = 64'd0, sel_b = 64'd0, sel_c = 64'd0;
    logic        flush = 1'b0;
    logic        issue_ready, out_set, ex_valid, wb_v;
    logic [5:0]  out_rid, ex_rid, wb_rid;
    logic [31:0] ex_ir;
    logic [63:0] ex_a, ex_b, ex_c, wb_res;
    logic        ex_done = 1'b0;
    logic [63:0] ex_res = 64'd0;
    logic [7:0]  ex_exc = 8'd0, wb_exc;

    any1_issue_unit #(.ROB_ENTRIES(64), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .selection(selection), .sel_ir(sel_ir),
        .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c), .flush(flush),
        .issue_ready(issue_ready), .out_set(out_set), .out_rid(out_rid),
        .ex_valid(ex_valid), .ex_rid(ex_rid), .ex_ir(ex_ir),
        .ex_a(ex_a), .ex_b(ex_b), .ex_c(ex_c),
        .ex_done(ex_done), .ex_res(ex_res), .ex_exc(ex_exc),
        .wb_v(wb_v), .wb_rid(wb_rid), .wb_res(wb_res), .wb_exc(wb_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  rid;
        logic [31:0] ir;
        logic [63:0] a, b, c;
    } op_t;
    typedef struct {
        logic [5:0]  rid;
        logic [63:0] res;
        logic [7:0]  exc;
    } wbe_t;

    op_t  set_q[$];
    wbe_t wb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_set = 0, n_wb = 0, n_exv = 0;
    bit   started = 1'b0;

    // Reference model: an op is either executing, awaiting writeback, or absent.
    bit          m_busy = 1'b0, m_wb = 1'b0, m_fresh = 1'b0;
    int          m_wait = 0;
    op_t         m_op;
    logic [63:0] m_res = 64'd0;
    logic [7:0]  m_exc = 8'd0;
    bit          exp_ready = 1'b0, exp_exv = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the rules for one clock edge using the inputs present at that edge.
    task automatic model_edge();
        m_fresh = 1'b0;
        if (rst || flush) begin
            m_busy = 1'b0;
            m_wb   = 1'b0;
        end else if (m_wb) begin
            m_wb = 1'b0;
        end else if (m_busy) begin
            if (ex_done) begin
                m_busy = 1'b0;
                m_wb   = 1'b1;
                m_res  = ex_res;
                m_exc  = ex_exc;
            end else begin
                m_wait++;
`ifdef ANY1_ISSUE_TIMEOUT_EN
                if (m_wait == int'(TO)) begin
                    m_busy = 1'b0;
                    m_wb   = 1'b1;
                    m_res  = 64'd0;
                    m_exc  = 8'hFE;
                end
`endif
            end
        end else if (!selection[6]) begin
            m_busy  = 1'b1;
            m_fresh = 1'b1;
            m_wait  = 0;
            m_op.rid = selection[5:0];
            m_op.ir  = sel_ir;
            m_op.a   = sel_a;
            m_op.b   = sel_b;
            m_op.c   = sel_c;
        end
    endtask

    task automatic step(input logic r, input logic f, input logic [6:0] s, input logic d,
                        input logic [63:0] res, input logic [7:0] exc, input logic [63:0] a);
        wbe_t w;
        @(posedge clk);
        model_edge();
        #1;
        rst       = r;
        flush     = f;
        selection = s;
        ex_done   = d;
        ex_res    = res;
        ex_exc    = exc;
        sel_a     = a;
        sel_ir    = $urandom;
        sel_b     = {$urandom, $urandom};
        sel_c     = {$urandom, $urandom};
        exp_ready = !m_busy && !m_wb && !r && !f;
        exp_exv   = m_busy && !r && !f;
        if (m_fresh && !r && !f) set_q.push_back(m_op);
        if (m_wb && !r && !f) begin
            w.rid = m_op.rid;
            w.res = m_res;
            w.exc = m_exc;
            wb_q.push_back(w);
        end
        started = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 7'h7F, 1'b0, 64'd0, 8'd0, 64'd0);
    endtask

    // Monitor: pops expectations whenever the DUT strobes an output.
    always @(negedge clk) begin
        if (started) begin
            op_t  o;
            wbe_t w;
            chk("issue_ready", 64'(issue_ready), 64'(exp_ready));
            chk("ex_valid", 64'(ex_valid), 64'(exp_exv));
            n_cmp++;
            if (ex_valid && wb_v) begin
                n_bad++;
                $display("FAIL wb_v_with_ex_valid: got both high expected exclusive at %0t", $time);
            end
            if (ex_valid) begin
                n_exv++;
                if (exp_exv) begin
                    chk("ex_rid_stable", 64'(ex_rid), 64'(m_op.rid));
                    chk("ex_a_stable", ex_a, m_op.a);
                    chk("ex_ir_stable", 64'(ex_ir), 64'(m_op.ir));
                end
            end
            if (out_set) begin
                n_set++;
                if (set_q.size() == 0) begin
                    chk("out_set_unexpected", 64'(out_set), 64'd0);
                end else begin
                    o = set_q.pop_front();
                    chk("out_rid", 64'(out_rid), 64'(o.rid));
                    chk("set_ex_ir", 64'(ex_ir), 64'(o.ir));
                    chk("set_ex_a", ex_a, o.a);
                    chk("set_ex_b", ex_b, o.b);
                    chk("set_ex_c", ex_c, o.c);
                end
            end
            if (wb_v) begin
                n_wb++;
                if (wb_q.size() == 0) begin
                    chk("wb_v_unexpected", 64'(wb_v), 64'd0);
                end else begin
                    w = wb_q.pop_front();
                    chk("wb_rid", 64'(wb_rid), 64'(w.rid));
                    chk("wb_res", wb_res, w.res);
                    chk("wb_exc", 64'(wb_exc), 64'(w.exc));
                end
            end
            if (set_q.size() != 0) begin
                chk("out_set_missing", 64'(out_set), 64'd1);
                set_q.delete();
            end
            if (wb_q.size() != 0) begin
                chk("wb_v_missing", 64'(wb_v), 64'd1);
                wb_q.delete();
            end
        end
    end

    initial begin
        int s0, w0, x0;
        // Reset held two cycles, then released.
        step(1'b1, 1'b0, 7'h7F, 1'b0, 64'd0, 8'd0, 64'd0);
        step(1'b1, 1'b0, 7'h05, 1'b1, 64'd0, 8'd0, 64'd0);
        @(negedge clk);
        chk("rst_ex_rid", 64'(ex_rid), 64'd0);
        chk("rst_ex_a", ex_a, 64'd0);
        chk("rst_wb_res", wb_res, 64'd0);
        chk("rst_wb_exc", 64'(wb_exc), 64'd0);
        chk("rst_out_rid", 64'(out_rid), 64'd0);
        idle(1);

        // Single-cycle op on rid 5.
        s0 = n_wb;
        step(1'b0, 1'b0, 7'h05, 1'b0, 64'd0, 8'd0, 64'h11);
        step(1'b0, 1'b0, 7'h7F, 1'b1, 64'h22, 8'd0, 64'd0);
        idle(2);
        chk("single_wb_count", 64'(n_wb - s0), 64'd1);

        // Multicycle op on rid 12 with rid 13 picks ignored.
        s0 = n_wb;
        w0 = n_set;
        step(1'b0, 1'b0, 7'd12, 1'b0, 64'd0, 8'd0, 64'hA5A5_0000_1234_5678);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 7'd13, 1'b0, 64'd0, 8'd0, 64'hDEAD);
        step(1'b0, 1'b0, 7'd13, 1'b1, 64'h33, 8'h01, 64'hDEAD);
        step(1'b0, 1'b0, 7'h7F, 1'b0, 64'd0, 8'd0, 64'd0);
        idle(1);
        chk("multi_wb_count", 64'(n_wb - s0), 64'd1);
        chk("multi_set_count", 64'(n_set - w0), 64'd1);

        // No picks for 20 cycles.
        s0 = n_set; w0 = n_wb; x0 = n_exv;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 7'h7F, 1'($urandom_range(0, 1)), 64'h44, 8'd0, 64'd0);
        chk("nopick_set", 64'(n_set - s0), 64'd0);
        chk("nopick_wb", 64'(n_wb - w0), 64'd0);
        chk("nopick_exv", 64'(n_exv - x0), 64'd0);

        // Flush on third EXEC cycle with coincident done, then rid 0 runs normally.
        s0 = n_wb;
        step(1'b0, 1'b0, 7'd63, 1'b0, 64'd0, 8'd0, 64'h63);
        step(1'b0, 1'b0, 7'h7F, 1'b0, 64'd0, 8'd0, 64'd0);
        step(1'b0, 1'b0, 7'h7F, 1'b0, 64'd0, 8'd0, 64'd0);
        step(1'b0, 1'b1, 7'h7F, 1'b1, 64'h55, 8'd0, 64'd0);
        idle(1);
        chk("flush_wb_count", 64'(n_wb - s0), 64'd0);
        step(1'b0, 1'b0, 7'd0, 1'b0, 64'd0, 8'd0, 64'h66);
        step(1'b0, 1'b0, 7'h7F, 1'b1, 64'h77, 8'h02, 64'd0);
        idle(2);
        chk("after_flush_wb_count", 64'(n_wb - s0), 64'd1);

`ifdef ANY1_ISSUE_TIMEOUT_EN
        // Watchdog: rid 7 never completes; late done in WB is ignored.
        s0 = n_wb;
        step(1'b0, 1'b0, 7'd7, 1'b0, 64'd0, 8'd0, 64'h70);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 7'h7F, 1'b0, 64'd0, 8'd0, 64'd0);
        step(1'b0, 1'b0, 7'h7F, 1'b1, 64'h88, 8'h03, 64'd0);
        idle(2);
        chk("timeout_wb_count", 64'(n_wb - s0), 64'd1);
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] s;
            s = ($urandom_range(0, 9) < 3) ? 7'h7F : 7'($urandom_range(0, 63));
            step(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 6), s,
                 1'($urandom_range(0, 9) < 3), {$urandom, $urandom}, 8'($urandom),
                 {$urandom, $urandom});
        end
        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
